// File: rtl/eth10base_t_pkg.sv
// Shared 10BASE-T definitions: receive state encoding, framing and CRC-32 constants,
// and the byte-wide reflected CRC step used by both the rx checker and the tx FCS generator.
package eth10base_t_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    END
  } rx_state_e;

  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Residue in normal (MSB-first) bit order; the reflected register is compared after reflect32().
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // One byte of the LSB-first CRC, matching the on-wire bit order.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ reflect32(CRC_POLY);
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/eth10base_t_rx_if.sv
// Byte stream from the 10BASE-T receiver to the MAC frame buffer.
interface eth10base_t_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_crc_ok;
  logic       rx_err;

  modport master (output rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err);
  modport slave  (input  rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err);
endinterface

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 register (poly 0x04C11DB7, init all ones, no final inversion).
module eth_crc32
  import eth10base_t_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc32_byte(crc, data);
  end

endmodule

// File: rtl/eth10base_t_rx.sv
// 10BASE-T receiver: Manchester clock/data recovery, preamble/SFD strip, byte delivery
// with CRC-32 check, and link integrity from normal link pulses and received frames.
module eth10base_t_rx
  import eth10base_t_pkg::*;
#(
  parameter int HALF_BIT     = 5,
  parameter int LINK_TIMEOUT = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Rxp,
  input  logic             Rxn,
  eth10base_t_rx_if.master rx,
  output logic             link_up,
  output logic             Led_Rx
);

  localparam int CNT_MAX = 3 * HALF_BIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LT_W    = $clog2(LINK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] MID_C  = CNT_W'(3 * HALF_BIT / 2);
  localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(CNT_MAX);
  // Falling edge of an NLP arrives at cnt = width-1; width window is HALF_BIT..3*HALF_BIT.
  localparam logic [CNT_W-1:0] NLP_LO = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] NLP_HI = CNT_W'(3 * HALF_BIT - 1);
  localparam logic [LT_W-1:0]  LT_MAX = LT_W'(LINK_TIMEOUT);
  localparam logic [LT_W-1:0]  LT_END = LT_W'(LINK_TIMEOUT - 1);
  localparam logic [1:0]       SFD_TAIL = SFD[7:6];

  logic [1:0]       rxp_sync, rxn_sync;
  logic             line, line_d, edge_det, accept, timeout_hit;
  logic [CNT_W-1:0] cnt;
  rx_state_e        state_q, state_d;
  logic             enter_data;
  logic             prev_bit;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt;
  logic             first_byte, got_byte;
  logic             nlp_arm, nlp_cand, nlp_hit;
  logic [LT_W-1:0]  link_timer;
  logic             crc_init;
  logic [31:0]      crc;

  // Rxp/Rxn are asynchronous to clk; a matching pair (both 0 or both 1) reads as idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxp_sync <= '0;
      rxn_sync <= '0;
      line_d   <= 1'b0;
    end else begin
      rxp_sync <= {rxp_sync[0], Rxp};
      rxn_sync <= {rxn_sync[0], Rxn};
      line_d   <= line;
    end
  end

  assign line     = (rxp_sync[1] != rxn_sync[1]) ? rxp_sync[1] : 1'b0;
  assign edge_det = line ^ line_d;
  // Edges closer than 1.5 half-bits to the last accepted edge are bit-boundary edges.
  assign accept      = edge_det && ((state_q == IDLE) || (cnt >= MID_C));
  assign timeout_hit = (cnt == TMO_C) && !accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt <= TMO_C;
    else if (accept)        cnt <= '0;
    else if (cnt != TMO_C)  cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = PREAMBLE;
      PREAMBLE: begin
        if (accept && ({line, prev_bit} == SFD_TAIL)) state_d = DATA;
        else if (timeout_hit)                         state_d = IDLE;
      end
      DATA:     if (timeout_hit) state_d = END;
      END:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign enter_data = (state_q == PREAMBLE) && (state_d == DATA);
  assign Led_Rx     = (state_q == PREAMBLE) || (state_q == DATA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_bit     <= 1'b0;
      shift_q      <= '0;
      bit_cnt      <= '0;
      first_byte   <= 1'b0;
      got_byte     <= 1'b0;
      rx.rx_data   <= '0;
      rx.rx_valid  <= 1'b0;
      rx.rx_sof    <= 1'b0;
      rx.rx_eof    <= 1'b0;
      rx.rx_crc_ok <= 1'b0;
      rx.rx_err    <= 1'b0;
    end else begin
      rx.rx_valid  <= 1'b0;
      rx.rx_sof    <= 1'b0;
      rx.rx_eof    <= 1'b0;
      rx.rx_crc_ok <= 1'b0;
      rx.rx_err    <= 1'b0;

      if (accept && ((state_q == IDLE) || (state_q == PREAMBLE))) prev_bit <= line;

      if (enter_data) begin
        bit_cnt    <= '0;
        first_byte <= 1'b1;
        got_byte   <= 1'b0;
      end else if ((state_q == DATA) && accept) begin
        shift_q <= {line, shift_q[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx.rx_data  <= {line, shift_q[7:1]};
          rx.rx_valid <= 1'b1;
          rx.rx_sof   <= first_byte;
          first_byte  <= 1'b0;
          got_byte    <= 1'b1;
        end
      end

      // A trailing partial byte is dropped and flagged as dribble.
      if ((state_q == DATA) && timeout_hit) begin
        rx.rx_eof    <= 1'b1;
        rx.rx_crc_ok <= (reflect32(crc) == CRC_RESIDUE);
        rx.rx_err    <= (bit_cnt != 3'd0) || !got_byte;
      end
    end
  end

  assign crc_init = (state_q == IDLE) && accept;

  eth_crc32 u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (crc_init),
    .en    (rx.rx_valid),
    .data  (rx.rx_data),
    .crc   (crc)
  );

  // An NLP looks like a short excursion into PREAMBLE: one rising edge from IDLE,
  // one falling edge inside the width window, then silence until the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nlp_arm  <= 1'b0;
      nlp_cand <= 1'b0;
    end else if (state_q == IDLE) begin
      nlp_arm  <= accept && line;
      nlp_cand <= 1'b0;
    end else if (edge_det) begin
      nlp_arm  <= 1'b0;
      nlp_cand <= nlp_arm && !line && (cnt >= NLP_LO) && (cnt <= NLP_HI);
    end
  end

  assign nlp_hit = (state_q == PREAMBLE) && timeout_hit && nlp_cand && !line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_timer <= LT_MAX;
      link_up    <= 1'b0;
    end else if (nlp_hit || rx.rx_sof) begin
      link_timer <= '0;
      link_up    <= 1'b1;
    end else if (link_timer != LT_MAX) begin
      link_timer <= link_timer + LT_W'(1);
      if (link_timer == LT_END) link_up <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eth10base_t_rx.sv
// Directed bench for eth10base_t_rx: Manchester frames, CRC and dribble cases, NLP link
// integrity and reset mid-frame, against a bit-serial MSB-first CRC model.
module tb_eth10base_t_rx;

  localparam int HB         = 5;
  localparam int LT         = 8000;
  localparam int NLP_PERIOD = 2560;
  localparam int N_PAY      = 60;

  logic clk = 1'b0;
  logic reset, Rxp, Rxn, link_up, Led_Rx;

  eth10base_t_rx_if rx_if ();

  eth10base_t_rx #(.HALF_BIT(HB), .LINK_TIMEOUT(LT)) dut (
    .clk     (clk),
    .reset   (reset),
    .Rxp     (Rxp),
    .Rxn     (Rxn),
    .rx      (rx_if),
    .link_up (link_up),
    .Led_Rx  (Led_Rx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int   sof_cnt = 0, sof_idx = -1, eof_cnt = 0, overlap_cnt = 0;
  logic last_crc_ok = 1'b0, last_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_if.rx_valid) begin
        if (rx_if.rx_sof) begin
          sof_cnt++;
          sof_idx = got_q.size();
        end
        got_q.push_back(rx_if.rx_data);
      end
      if (rx_if.rx_eof) begin
        eof_cnt++;
        last_crc_ok = rx_if.rx_crc_ok;
        last_err    = rx_if.rx_err;
        if (rx_if.rx_valid) overlap_cnt++;
      end
    end
  end

  // 0 = line low, 1 = line high, 2 = idle (pair undriven).
  task automatic drive(input int lvl);
    Rxp = (lvl == 1);
    Rxn = (lvl == 0);
  endtask

  task automatic send_bit(input logic b);
    drive(b ? 0 : 1);
    repeat (HB) @(negedge clk);
    drive(b ? 1 : 0);
    repeat (HB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic go_idle(input int clocks);
    drive(2);
    repeat (clocks) @(negedge clk);
  endtask

  function automatic logic [7:0] pay_byte(input int i);
    return 8'(i * 13 + 1);
  endfunction

  // MSB-first CRC over wire-order bits; FCS goes out as the complement, x^31 term first.
  function automatic logic [31:0] crc_model();
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < N_PAY; i++) begin
      b = pay_byte(i);
      for (int j = 0; j < 8; j++) begin
        fb = c[31] ^ b[j];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    return c;
  endfunction

  task automatic send_header();
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  task automatic send_frame(input int flip_byte, input int extra_bits);
    logic [31:0] c;
    logic [7:0]  b;
    logic [3:0]  xb;
    exp_q.delete();
    c  = crc_model();
    xb = 4'b1101;
    send_header();
    for (int i = 0; i < N_PAY; i++) begin
      b = pay_byte(i);
      if (i == flip_byte) b = b ^ 8'h08;
      exp_q.push_back(b);
      send_byte(b);
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) b[j] = ~c[31 - (8 * k + j)];
      exp_q.push_back(b);
      send_byte(b);
    end
    for (int e = 0; e < extra_bits; e++) send_bit(xb[e]);
    drive(2);
  endtask

  task automatic check_frame(input string tag, input int q_base, input int sof_base,
                             input int eof_base, input int ovl_base,
                             input logic exp_ok, input logic exp_err);
    for (int i = 0; i < 400 && eof_cnt == eof_base; i++) @(negedge clk);
    check($sformatf("%s/eof_count", tag), eof_cnt, eof_base + 1);
    check($sformatf("%s/byte_count", tag), got_q.size() - q_base, exp_q.size());
    check($sformatf("%s/sof_count", tag), sof_cnt - sof_base, 1);
    check($sformatf("%s/sof_index", tag), sof_idx, q_base);
    for (int i = 0; i < exp_q.size(); i++)
      if (q_base + i < got_q.size())
        check($sformatf("%s/byte%0d", tag, i), got_q[q_base + i], exp_q[i]);
    check($sformatf("%s/crc_ok", tag), last_crc_ok, exp_ok);
    check($sformatf("%s/err", tag), last_err, exp_err);
    check($sformatf("%s/valid_eof_overlap", tag), overlap_cnt - ovl_base, 0);
  endtask

  task automatic run_frame(input string tag, input int flip_byte, input int extra_bits,
                           input logic exp_ok, input logic exp_err);
    int q_base, sof_base, eof_base, ovl_base;
    q_base   = got_q.size();
    sof_base = sof_cnt;
    eof_base = eof_cnt;
    ovl_base = overlap_cnt;
    send_frame(flip_byte, extra_bits);
    check_frame(tag, q_base, sof_base, eof_base, ovl_base, exp_ok, exp_err);
    check($sformatf("%s/led_after", tag), Led_Rx, 1'b0);
  endtask

  task automatic send_pulse(input int width);
    drive(1);
    repeat (width) @(negedge clk);
    drive(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    check($sformatf("%s/rx_data", tag), rx_if.rx_data, 8'h00);
    check($sformatf("%s/rx_valid", tag), rx_if.rx_valid, 1'b0);
    check($sformatf("%s/rx_sof", tag), rx_if.rx_sof, 1'b0);
    check($sformatf("%s/rx_eof", tag), rx_if.rx_eof, 1'b0);
    check($sformatf("%s/rx_crc_ok", tag), rx_if.rx_crc_ok, 1'b0);
    check($sformatf("%s/rx_err", tag), rx_if.rx_err, 1'b0);
    check($sformatf("%s/link_up", tag), link_up, 1'b0);
    check($sformatf("%s/led", tag), Led_Rx, 1'b0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int eof_base, q_base, waited;

    reset = 1'b1;
    drive(2);
    repeat (7) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    go_idle(20);
    check("idle/link_up", link_up, 1'b0);
    check("idle/led", Led_Rx, 1'b0);

    run_frame("good", -1, 0, 1'b1, 1'b0);
    check("good/link_up", link_up, 1'b1);
    go_idle(50);

    run_frame("bitflip", 10, 0, 1'b0, 1'b0);
    go_idle(50);

    run_frame("dribble", -1, 4, 1'b1, 1'b1);

    // Link must lapse on its own with no pulses or frames.
    waited = 0;
    while (link_up && waited < LT + 200) begin
      @(negedge clk);
      waited++;
    end
    check("link/timeout_drop", link_up, 1'b0);

    eof_base = eof_cnt;
    q_base   = got_q.size();
    send_pulse(8 * HB);
    go_idle(100);
    check("nlp/too_long_ignored", link_up, 1'b0);

    for (int k = 0; k < 3; k++) begin
      send_pulse(2 * HB);
      go_idle(100);
      check($sformatf("nlp%0d/link_up", k), link_up, 1'b1);
      check($sformatf("nlp%0d/led", k), Led_Rx, 1'b0);
      if (k < 2) go_idle(NLP_PERIOD - 2 * HB - 100);
    end
    go_idle(LT - 200 - 2 * HB - 100);
    check("nlp/link_held", link_up, 1'b1);
    go_idle(500);
    check("nlp/link_drop", link_up, 1'b0);
    check("nlp/no_eof", eof_cnt, eof_base);
    check("nlp/no_bytes", got_q.size(), q_base);

    // Reset in the middle of the payload.
    eof_base = eof_cnt;
    send_header();
    for (int i = 0; i < 20; i++) send_byte(pay_byte(i));
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    check("midreset/link_before", link_up, 1'b1);
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    drive(2);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    go_idle(100);
    check("midreset/no_eof", eof_cnt, eof_base);
    check("midreset/led", Led_Rx, 1'b0);

    run_frame("after_reset", -1, 0, 1'b1, 1'b0);
    go_idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
